// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the instruction fetch path.
//   WORD_W        : datapath / address width
//   PC_STEP       : byte distance between consecutive instructions
//   PC_ALIGN_MASK : clears the byte-offset bits of an instruction address
//   fetch_pl_t    : payload handed to decode {pc, pc_plus4, instr}
//   align_pc()    : forces an address onto an instruction boundary
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP       = 32'd4;
    localparam logic [WORD_W-1:0] PC_ALIGN_MASK = ~(PC_STEP - 32'd1);

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc_plus4;
        logic [WORD_W-1:0] instr;
    } fetch_pl_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] a);
        return a & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf -- output register O plus one-entry skid register S.
//   clk, rst      : clock, synchronous active-high reset (clears valids and data)
//   flush_i       : drop both entries (valid only; data left as is)
//   in_valid_i    : a response is arriving this edge
//   in_ready_o    : skid slot empty, upstream may issue another fetch
//   in_data_i     : arriving payload
//   out_valid_o   : O holds a payload
//   out_ready_i   : downstream accepts O this edge
//   out_data_o    : payload held in O (stable while stalled)
// Upstream only issues while S is empty and O is not stalled, so at most one
// response can land while O is stalled and S never overflows.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  fetch_pl_t in_data_i,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output fetch_pl_t out_data_o
);

    logic      o_valid_q, o_valid_d;
    logic      s_valid_q, s_valid_d;
    fetch_pl_t o_data_q,  o_data_d;
    fetch_pl_t s_data_q,  s_data_d;
    logic      o_free;

    // O can take new data if it is empty or being consumed on this edge.
    assign o_free = !o_valid_q || out_ready_i;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (o_free) begin
            if (s_valid_q) begin
                // Older skid entry goes first; a concurrent arrival refills S.
                o_valid_d = 1'b1;
                o_data_d  = s_data_q;
                s_valid_d = in_valid_i;
                if (in_valid_i) s_data_d = in_data_i;
            end else if (in_valid_i) begin
                o_valid_d = 1'b1;
                o_data_d  = in_data_i;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (in_valid_i) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data_i;
        end
        if (flush_i) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            s_valid_q <= s_valid_d;
            o_data_q  <= o_data_d;
            s_data_q  <= s_data_d;
        end
    end

    assign in_ready_o  = !s_valid_q;
    assign out_valid_o = o_valid_q;
    assign out_data_o  = o_data_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage -- program counter and instruction fetch front end.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   redirect_valid : branch/jump redirect (flushes everything in flight)
//   redirect_pc    : redirect target (byte offset bits are dropped)
//   imem_addr      : instruction memory address (= pc)
//   imem_rdata     : synchronous-read data for last cycle's imem_addr
//   out_valid      : instruction available to decode
//   out_ready      : decode accepts this cycle
//   out_pc / out_pc_plus4 / out_instr : presented instruction
//   misalign_err   : sticky misaligned-redirect flag (MISALIGN_TRAP_EN only)
// Build option: define MISALIGN_TRAP_EN to add misalign_err.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_pc_plus4,
    output logic [WORD_W-1:0] out_instr
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              skid_in_ready;
    logic              issue;
    fetch_pl_t         resp;
    fetch_pl_t         out_data;

    // Never issue into a full skid slot or while the output is stalled:
    // that guarantees room for the one response already in flight.
    assign issue = skid_in_ready && !(out_valid && !out_ready);

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d          = pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign resp.pc       = inflight_pc_q;
    assign resp.pc_plus4 = inflight_pc_q + PC_STEP;
    assign resp.instr    = imem_rdata;

    fetch_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .in_valid_i  (inflight_q),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (resp),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    assign imem_addr    = pc_q;
    assign out_pc       = out_data.pc;
    assign out_pc_plus4 = out_data.pc_plus4;
    assign out_instr    = out_data.instr;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus a randomized run checked
// against an in-order address-stream model (each transfer must be the next
// sequential address since the last reset/redirect).
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata, out_pc, out_pc_plus4, out_instr;
    logic        out_valid;
    logic [31:0] b_addr, b_rdata, b_pc, b_plus4, b_instr;
    logic        b_valid;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err, b_misalign;
`endif

    logic [31:0] salt = 32'h0;
    int          tests_run = 0;
    int          fails = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ salt;
    endfunction

    always @(posedge clk) begin
        imem_rdata <= memf(imem_addr);
        b_rdata    <= memf(b_addr);
    end

    pc_fetch_stage dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_instr(out_instr)
`ifdef MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(b_addr), .imem_rdata(b_rdata), .out_valid(b_valid),
        .out_ready(out_ready), .out_pc(b_pc), .out_pc_plus4(b_plus4),
        .out_instr(b_instr)
`ifdef MISALIGN_TRAP_EN
        , .misalign_err(b_misalign)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        salt = 32'h0;
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h0 || out_instr !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b pc=%h p4=%h i=%h expected 0 0 0 0", out_valid, out_pc, out_pc_plus4, out_instr);
        end
        tests_run++;
        if (imem_addr !== 32'h0 || b_addr !== 32'hFFFF_FFF8) begin
            fails++;
            $display("FAIL reset_addr: got %h/%h expected 00000000/fffffff8", imem_addr, b_addr);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_edge1: got out_valid=%b expected 0", out_valid);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            fails++;
            $display("FAIL latency_edge2: got v=%b pc=%h expected 1 00000000", out_valid, out_pc);
        end
    endtask

    task automatic test_stream();
        salt = 32'h0;
        do_reset();
        step(); step();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] e;
            e = 32'(k * 4);
            tests_run++;
            if (out_valid !== 1'b1 || out_pc !== e || out_instr !== e || out_pc_plus4 !== e + 32'd4) begin
                fails++;
                $display("FAIL stream[%0d]: got v=%b pc=%h i=%h p4=%h expected pc=%h", k, out_valid, out_pc, out_instr, out_pc_plus4, e);
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        salt = 32'h0;
        do_reset();
        step(); step(); step(); step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'd8) begin
            fails++;
            $display("FAIL stall_setup: got v=%b pc=%h expected 1 00000008", out_valid, out_pc);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_pc !== 32'd8 || out_instr !== 32'd8 || out_pc_plus4 !== 32'd12) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h expected 1 00000008", i, out_valid, out_pc, out_instr);
            end
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'd12) begin
            fails++;
            $display("FAIL stall_release: got v=%b pc=%h expected 1 0000000c", out_valid, out_pc);
        end
        e = 32'd16;
        for (int n = 0; n < 3; n++) begin
            int cyc;
            cyc = 0;
            step();
            while (out_valid !== 1'b1 && cyc < 5) begin
                step();
                cyc++;
            end
            tests_run++;
            if (out_valid !== 1'b1 || out_pc !== e) begin
                fails++;
                $display("FAIL stall_follow[%0d]: got v=%b pc=%h expected 1 %h", n, out_valid, out_pc, e);
            end
            e = e + 32'd4;
        end
    endtask

    task automatic test_redirect();
        salt = 32'h0;
        do_reset();
        step(); step(); step(); step();
        out_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_flush0: got v=%b pc=%h expected v=0", out_valid, out_pc);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_flush1: got v=%b pc=%h expected v=0", out_valid, out_pc);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_pc_plus4 !== 32'h104 || out_instr !== 32'h100) begin
            fails++;
            $display("FAIL redirect_target: got v=%b pc=%h p4=%h expected 1 00000100 00000104", out_valid, out_pc, out_pc_plus4);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
            fails++;
            $display("FAIL redirect_next: got v=%b pc=%h expected 1 00000104", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        salt = 32'h0;
        do_reset();
        step(); step();
        tests_run++;
        if (b_valid !== 1'b1 || b_pc !== 32'hFFFF_FFF8 || b_plus4 !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap0: got v=%b pc=%h p4=%h expected 1 fffffff8 fffffffc", b_valid, b_pc, b_plus4);
        end
        step();
        tests_run++;
        if (b_valid !== 1'b1 || b_pc !== 32'hFFFF_FFFC || b_plus4 !== 32'h0 || b_instr !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap1: got v=%b pc=%h p4=%h i=%h expected 1 fffffffc 00000000", b_valid, b_pc, b_plus4, b_instr);
        end
        step();
        tests_run++;
        if (b_valid !== 1'b1 || b_pc !== 32'h0 || b_plus4 !== 32'h4) begin
            fails++;
            $display("FAIL wrap2: got v=%b pc=%h p4=%h expected 1 00000000 00000004", b_valid, b_pc, b_plus4);
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        salt = 32'h0;
        do_reset();
        tests_run++;
        if (misalign_err !== 1'b0) begin
            fails++;
            $display("FAIL misalign_reset: got %b expected 0", misalign_err);
        end
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if (misalign_err !== 1'b1) begin
            fails++;
            $display("FAIL misalign_set: got %b expected 1", misalign_err);
        end
        step(); step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || misalign_err !== 1'b1) begin
            fails++;
            $display("FAIL misalign_target: got v=%b pc=%h err=%b expected 1 00000100 1", out_valid, out_pc, misalign_err);
        end
        step(); step(); step();
        tests_run++;
        if (misalign_err !== 1'b1) begin
            fails++;
            $display("FAIL misalign_sticky: got %b expected 1", misalign_err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (misalign_err !== 1'b0) begin
            fails++;
            $display("FAIL misalign_clear: got %b expected 0", misalign_err);
        end
    endtask
`endif

    task automatic test_reset_midflight();
        salt = 32'h0;
        do_reset();
        step(); step(); step();
        out_ready = 1'b0; rst = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
            fails++;
            $display("FAIL midflight_reset: got v=%b addr=%h pc=%h expected 0 00000000 00000000", out_valid, imem_addr, out_pc);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midflight_gap: got v=%b expected 0", out_valid);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            fails++;
            $display("FAIL midflight_refetch: got v=%b pc=%h expected 1 00000000", out_valid, out_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_next, ppc, pplus, pinstr, tgt;
        logic        pv, pr, rv;
        int          since, xfers;
        salt = $urandom;
        do_reset();
        exp_next = 32'h0;
        since = 99;
        xfers = 0;
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            rv             = ($urandom_range(0, 19) == 0);
            redirect_valid = rv;
            redirect_pc    = $urandom;
            tgt            = redirect_pc & 32'hFFFF_FFFC;
            pv = out_valid; pr = out_ready;
            ppc = out_pc; pplus = out_pc_plus4; pinstr = out_instr;
            step();
            if (pv && pr) begin
                xfers++;
                tests_run++;
                if (ppc !== exp_next || pinstr !== memf(exp_next) || pplus !== exp_next + 32'd4) begin
                    fails++;
                    $display("FAIL rand_xfer@%0d: got pc=%h i=%h p4=%h expected pc=%h", c, ppc, pinstr, pplus, exp_next);
                end
                exp_next = exp_next + 32'd4;
            end
            if (rv) begin
                exp_next = tgt;
                since = 0;
                tests_run++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_flush@%0d: got v=%b expected 0", c, out_valid);
                end
            end else begin
                since++;
                if (pv && !pr) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || out_pc !== ppc || out_instr !== pinstr) begin
                        fails++;
                        $display("FAIL rand_stable@%0d: got v=%b pc=%h expected 1 %h", c, out_valid, out_pc, ppc);
                    end
                end
                if (since == 2) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || out_pc !== exp_next) begin
                        fails++;
                        $display("FAIL rand_target@%0d: got v=%b pc=%h expected 1 %h", c, out_valid, out_pc, exp_next);
                    end
                end
            end
        end
        redirect_valid = 1'b0;
        tests_run++;
        if (xfers < 600) begin
            fails++;
            $display("FAIL rand_progress: got %0d transfers expected at least 600", xfers);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Ports SHALL be: clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 redirect_valid  in  1  branch/jump redirect request.
REQ-005 redirect_pc  in  32  redirect target.
REQ-006 imem_addr  out  32  instruction memory address; equals current pc.
REQ-007 imem_rdata  in  32  synchronous-read data for the imem_addr presented one cycle earlier.
REQ-008 out_valid  out  1  fetched instruction available downstream.
REQ-009 out_ready  in  1  downstream (decode) accepts; transfer when out_valid && out_ready.
REQ-010 out_pc, out_pc_plus4, out_instr  out  32 each  address, address+4 and word of the presented instruction.
REQ-011 misalign_err  out  1  present only when MISALIGN_TRAP_EN is defined.

Function
REQ-012 The block SHALL hold pc, an inflight flag with inflight_pc, output register O, and a one-entry skid register S.
REQ-013 An issue SHALL occur on every non-reset edge where S is empty and not (O valid && !out_ready); the issue sets pc <= pc+4, sets inflight, and loads inflight_pc <= pc.
REQ-014 On an edge where inflight is set, the response {inflight_pc, imem_rdata} SHALL load O if O is empty or out_ready is high, otherwise S.
REQ-015 When O is consumed and S is valid, S SHALL move into O on that edge and S SHALL clear.
REQ-016 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); out_pc_plus4 SHALL wrap identically.
REQ-017 Latency: the first out_valid SHALL rise two edges after the last reset edge; steady-state throughput SHALL be one instruction per cycle with out_ready held high.
REQ-018 On redirect_valid at an edge, the block SHALL set pc <= {redirect_pc[31:2],2'b00} and clear inflight, O and S (flush), regardless of stall state; a redirect overrides the issue on that edge.
REQ-019 No instruction fetched before a redirect SHALL appear on out_* after it; the target SHALL appear on out_* two edges after the redirect edge.
REQ-020 out_* data SHALL stay stable while out_valid && !out_ready.
REQ-021 pc SHALL not advance while the issue condition is false.

Reset
REQ-022 While rst is high at an edge: pc <= RESET_PC; inflight, O.valid and S.valid clear; misalign_err clears; out_valid SHALL be 0 the cycle after.
REQ-023 rst SHALL take priority over redirect_valid and any in-flight response, including mid-stall.
REQ-024 out_pc, out_pc_plus4 and out_instr SHALL reset to 0.

Configuration
REQ-025 Macro MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0] != 0 SHALL set misalign_err high on that edge, sticky until rst; pc still aligns per REQ-018.
REQ-026 Macro undefined: misalign_err port and logic SHALL be absent; misaligned targets are silently aligned.

Structure
REQ-027 Shared package mips_pkg SHALL hold WORD_W=32, PC_STEP=4 and the fetch-payload struct {pc, pc_plus4, instr}.
REQ-028 O plus S SHALL be a sub-module fetch_skid_buf (valid/ready in and out, one payload struct).

Verification
REQ-029 Reset release, out_ready=1, imem word = address -> out_pc 0,4,8,... on consecutive cycles, first valid two edges after reset.
REQ-030 out_ready low for 3 cycles after out_pc=8 -> out_pc holds 8, no instruction lost or duplicated; out_pc 12 follows on release.
REQ-031 redirect_pc=32'h0000_0100 during stall -> 8/12 never presented; out_pc=0x100 two edges later.
REQ-032 RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 for FFFF_FFFC is 0.
REQ-033 With MISALIGN_TRAP_EN, redirect_pc=32'h0000_0102 -> misalign_err=1 sticky, out_pc=0x100; rst clears it.
REQ-034 rst asserted with out_valid high and inflight set -> out_valid 0 next cycle, refetch from RESET_PC.
